// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file writeback path: request payload and source ids.
package regfile_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback queue. Ready is registered from next-cycle occupancy and exposes
// per-entry valid/addr so the owner can run a busy compare over queued writes.
module wb_fifo
    import regfile_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_req_t                      din,
    input  logic                         pop,
    output wb_req_t                      head,
    output logic                         empty,
    output logic                         full,
    output logic                         ready,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    assign count_nxt = count + CW'(push) - CW'(pop);
    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            ready <= (count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Slot i holds a live entry when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_ptr;
            entry_valid[i] = (CW'(off) < count);
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and MEM writebacks onto the single register-file write port.
// WB_ROUND_ROBIN_EN selects round robin; otherwise MEM has fixed priority over ALU.
module regfile_wb_arbiter #(
    parameter int DATA_W     = regfile_ctrl_pkg::DATA_W,
    parameter int ADDR_W     = regfile_ctrl_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] query_reg_1,
    input  logic [ADDR_W-1:0] query_reg_2,
    output logic              busy_1,
    output logic              busy_2,
    output logic              idle
);
    import regfile_ctrl_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_req_t alu_req, mem_req, alu_head, mem_head, gnt_req;
    logic    alu_push, mem_push, alu_pop, mem_pop;
    logic    alu_empty, mem_empty, alu_full, mem_full;
    logic [CW-1:0]                    alu_occ, mem_occ;
    logic [FIFO_DEPTH-1:0]             alu_ev, mem_ev;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] alu_ea, mem_ea;
    wb_src_t gnt_src;
    logic    gnt;

    assign alu_req  = '{addr: alu_reg, data: alu_data};
    assign mem_req  = '{addr: mem_reg, data: mem_data};
    assign alu_push = alu_valid && alu_ready && !alu_full;
    assign mem_push = mem_valid && mem_ready && !mem_full;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst), .push(alu_push), .din(alu_req), .pop(alu_pop),
        .head(alu_head), .empty(alu_empty), .full(alu_full), .ready(alu_ready),
        .occupancy(alu_occ), .entry_valid(alu_ev), .entry_addr(alu_ea)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk(clk), .rst(rst), .push(mem_push), .din(mem_req), .pop(mem_pop),
        .head(mem_head), .empty(mem_empty), .full(mem_full), .ready(mem_ready),
        .occupancy(mem_occ), .entry_valid(mem_ev), .entry_addr(mem_ea)
    );

`ifdef WB_ROUND_ROBIN_EN
    // rr_ptr names the source that wins the next contested cycle.
    wb_src_t rr_ptr;

    always_comb begin
        gnt = !alu_empty || !mem_empty;
        if (!alu_empty && !mem_empty) gnt_src = rr_ptr;
        else                          gnt_src = mem_empty ? SRC_ALU : SRC_MEM;
    end

    always_ff @(posedge clk) begin
        if (rst)      rr_ptr <= SRC_ALU;
        else if (gnt) rr_ptr <= (gnt_src == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
`else
    always_comb begin
        gnt     = !alu_empty || !mem_empty;
        gnt_src = mem_empty ? SRC_ALU : SRC_MEM;
    end
`endif

    assign gnt_req = (gnt_src == SRC_MEM) ? mem_head : alu_head;
    assign alu_pop = gnt && (gnt_src == SRC_ALU);
    assign mem_pop = gnt && (gnt_src == SRC_MEM);

    // Writes to r0 still drain through the port slot but never assert the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            RegWrite <= gnt && (gnt_req.addr != '0);
            if (gnt) begin
                write_reg  <= gnt_req.addr;
                write_data <= gnt_req.data;
            end
        end
    end

    assign idle = (alu_occ == '0) && (mem_occ == '0) && !RegWrite;

    always_comb begin
        busy_1 = 1'b0;
        busy_2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            busy_1 = busy_1 || (alu_ev[i] && alu_ea[i] == query_reg_1)
                            || (mem_ev[i] && mem_ea[i] == query_reg_1);
            busy_2 = busy_2 || (alu_ev[i] && alu_ea[i] == query_reg_2)
                            || (mem_ev[i] && mem_ea[i] == query_reg_2);
        end
        busy_1 = busy_1 && (query_reg_1 != '0);
        busy_2 = busy_2 && (query_reg_2 != '0);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_reg, mem_reg, query_reg_1, query_reg_2, write_reg;
    logic [DW-1:0] alu_data, mem_data, write_data;
    logic          RegWrite, busy_1, busy_2, idle;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
        .busy_1(busy_1), .busy_2(busy_2), .idle(idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: each source is a plain queue of {reg,data}; the port is one write slot.
    logic [AW+DW-1:0] aq[$];
    logic [AW+DW-1:0] mq[$];
    logic             m_rw = 1'b0;
    logic [AW-1:0]    m_wr = '0;
    logic [DW-1:0]    m_wd = '0;
    logic             m_rdy_a = 1'b0;
    logic             m_rdy_m = 1'b0;
    logic             mem_turn = 1'b0;

    function automatic logic queued(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        foreach (aq[i]) if (aq[i][AW+DW-1:DW] == r) return 1'b1;
        foreach (mq[i]) if (mq[i][AW+DW-1:DW] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [AW+DW-1:0] e;
        logic a_acc, m_acc, take_mem, any;
        if (rst) begin
            aq.delete(); mq.delete();
            m_rw = 0; m_wr = '0; m_wd = '0;
            m_rdy_a = 0; m_rdy_m = 0; mem_turn = 0;
            return;
        end
        a_acc = alu_valid && m_rdy_a;
        m_acc = mem_valid && m_rdy_m;
        any   = (aq.size() > 0) || (mq.size() > 0);
`ifdef WB_ROUND_ROBIN_EN
        if (aq.size() > 0 && mq.size() > 0) take_mem = mem_turn;
        else                                 take_mem = (mq.size() > 0);
`else
        take_mem = (mq.size() > 0);
`endif
        if (any) begin
            e = take_mem ? mq.pop_front() : aq.pop_front();
            m_wr = e[AW+DW-1:DW];
            m_wd = e[DW-1:0];
            m_rw = (m_wr != 0);
            mem_turn = !take_mem;
        end else begin
            m_rw = 0;
        end
        if (a_acc) aq.push_back({alu_reg, alu_data});
        if (m_acc) mq.push_back({mem_reg, mem_data});
        m_rdy_a = (aq.size() < DEPTH);
        m_rdy_m = (mq.size() < DEPTH);
    endtask

    // Drive one cycle's inputs at the falling edge, check outputs, then advance the model.
    task automatic cyc(input logic r, input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                       input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        query_reg_1 = q1; query_reg_2 = q2;
        #1;
        chk("regwrite", RegWrite, m_rw);
        if (m_rw) begin
            chk("write_reg", write_reg, m_wr);
            chk("write_data", write_data, m_wd);
        end
        chk("alu_ready", alu_ready, m_rdy_a);
        chk("mem_ready", mem_ready, m_rdy_m);
        chk("idle", idle, (aq.size() == 0) && (mq.size() == 0) && !m_rw);
        chk("busy_1", busy_1, queued(q1));
        chk("busy_2", busy_2, queued(q2));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, '0, '0, 0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        cyc(1, 0, '0, '0, 0, '0, '0, '0, '0);
        idle_cyc();
    endtask

    initial begin
        int idx;
        logic acc;
        rst = 1; alu_valid = 0; mem_valid = 0; alu_reg = '0; mem_reg = '0;
        alu_data = '0; mem_data = '0; query_reg_1 = '0; query_reg_2 = '0;
        @(posedge clk); @(negedge clk);

        // Reset held two cycles with a pending ALU request
        cyc(1, 1, 5'd4, 32'd11, 0, '0, '0, '0, '0);
        cyc(1, 1, 5'd4, 32'd11, 0, '0, '0, '0, '0);
        chk("rst_ready", alu_ready, 1'b0);
        chk("rst_idle", idle, 1'b1);
        repeat (3) idle_cyc();

        // Single ALU write: visible exactly in cycle 2
        cyc(0, 1, 5'd2, 32'd25, 0, '0, '0, '0, '0);
        chk("t2_c1_rw", RegWrite, 1'b0);
        idle_cyc();
        chk("t2_c2_rw", RegWrite, 1'b1);
        chk("t2_c2_reg", write_reg, 5'd2);
        chk("t2_c2_data", write_data, 32'd25);
        idle_cyc();
        chk("t2_c3_rw", RegWrite, 1'b0);
        idle_cyc();

        // Collision
        do_reset();
        cyc(0, 1, 5'd3, 32'd7, 1, 5'd5, 32'd9, '0, '0);
        idle_cyc();
`ifdef WB_ROUND_ROBIN_EN
        chk("t3_first", write_reg, 5'd3);
        idle_cyc();
        chk("t3_second", write_reg, 5'd5);
`else
        chk("t3_first", write_reg, 5'd5);
        idle_cyc();
        chk("t3_second", write_reg, 5'd3);
`endif
        repeat (2) idle_cyc();

        // Backpressure: three ALU writes while MEM keeps its FIFO non-empty
        do_reset();
        idx = 0;
        for (int k = 0; k < 6; k++) begin
`ifndef WB_ROUND_ROBIN_EN
            if (k == 2) chk("t4_stall", alu_ready, 1'b0);
`endif
            acc = alu_ready;
            cyc(0, idx < 3, AW'(10 + idx), DW'(100 + idx), 1, AW'(20 + k), DW'(k), '0, '0);
            if (acc && idx < 3) idx++;
        end
        for (int k = 0; k < 8; k++) begin
            acc = alu_ready;
            cyc(0, idx < 3, AW'(10 + idx), DW'(100 + idx), 0, '0, '0, 5'd11, 5'd12);
            if (acc && idx < 3) idx++;
        end
        chk("t4_all_accepted", idx, 3);

        // Busy lookup and r0
        do_reset();
        cyc(0, 1, 5'd5, 32'd1, 0, '0, '0, 5'd5, '0);
        chk("t5_busy_q", busy_1, 1'b1);
        idle_cyc();
        #1 chk("t5_busy_popped", busy_1, 1'b0);
        cyc(0, 0, '0, '0, 1, 5'd0, 32'd99, 5'd0, 5'd0);
        chk("t5_r0_busy", busy_2, 1'b0);
        idle_cyc();
        chk("t5_r0_rw", RegWrite, 1'b0);
        idle_cyc();

        // Mid-operation reset with both FIFOs loaded
        for (int k = 0; k < 3; k++)
            cyc(0, 1, AW'(1 + k), DW'(k), 1, AW'(8 + k), DW'(50 + k), '0, '0);
        cyc(1, 1, 5'd6, 32'd6, 1, 5'd7, 32'd7, '0, '0);
        chk("t6_idle", idle, 1'b1);
        chk("t6_rw", RegWrite, 1'b0);
        repeat (3) idle_cyc();

        // Random traffic
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        repeat (4) idle_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
